branch_decode_unit: RTL and testbench

BRANCH_DECODE_UNIT -- requirements
Module: branch_decode_unit

---
 rtl/branch_decode_pkg.sv | 56 +++++
 rtl/branch_lane_decode.sv | 73 +++++++
 rtl/branch_decode_unit.sv | 168 ++++++++++++++++
 tb/tb_branch_decode_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_decode_pkg.sv
// Shared definitions for the branch decode unit: opcode codes, flag layout,
// instruction classification and the decoded queue entry record.
package branch_decode_pkg;

    localparam logic [11:0] OPC_BC    = 12'd25;
    localparam logic [11:0] OPC_B     = 12'd26;
    localparam logic [11:0] OPC_BCLR  = 12'd27;
    localparam logic [11:0] OPC_BCCTR = 12'd28;

    localparam logic [2:0] BRANCH_UNIT_ID = 3'd6;

    // Bit positions inside the 5-bit flags field.
    localparam int FLAG_READS_CTR  = 4;
    localparam int FLAG_WRITES_CTR = 3;
    localparam int FLAG_READS_LR   = 2;
    localparam int FLAG_WRITES_LR  = 1;
    localparam int FLAG_UNCOND     = 0;

    localparam logic [5:0] PRIM_BC = 6'd16;
    localparam logic [5:0] PRIM_B  = 6'd18;
    localparam logic [5:0] PRIM_XL = 6'd19;
    localparam logic [9:0] XO_BCLR  = 10'd16;
    localparam logic [9:0] XO_BCCTR = 10'd528;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_BC,
        BR_B,
        BR_BCLR,
        BR_BCCTR
    } br_kind_e;

    typedef struct packed {
        logic [11:0] opcode;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [4:0]  flags;
    } queue_entry_t;

    // Instruction bit 0 (big-endian) is bit 31 here: primary = [0:5], XO = [21:30].
    function automatic br_kind_e classify(input logic [31:0] inst);
        br_kind_e kind;
        kind = BR_NONE;
        if (inst[31:26] == PRIM_BC) begin
            kind = BR_BC;
        end else if (inst[31:26] == PRIM_B) begin
            kind = BR_B;
        end else if (inst[31:26] == PRIM_XL && inst[10:1] == XO_BCLR) begin
            kind = BR_BCLR;
        end else if (inst[31:26] == PRIM_XL && inst[10:1] == XO_BCCTR) begin
            kind = BR_BCCTR;
        end
        return kind;
    endfunction

endpackage

// File: rtl/branch_lane_decode.sv
// Combinational decode of one instruction lane: classification, flags and
// branch target computation.
module branch_lane_decode
    import branch_decode_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              is64_i,
    output logic              valid_o,
    output queue_entry_t      dec_o,
    output logic [ADDR_W-1:0] target_o
);

    localparam logic [ADDR_W-1:0] LOW32_MASK = ADDR_W'({32{1'b1}});

    br_kind_e          kind;
    logic [4:0]        bo;
    logic [ADDR_W-1:0] offset;

    // BO[0] is the field MSB (bo[4]); BO[2] is bo[2].
    // NOTE: always_comb uses blocking assignments with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        kind     = classify(inst_i);
        bo       = inst_i[25:21];
        offset   = '0;
        target_o = '0;
        dec_o    = '0;
        dec_o.bo = bo;
        dec_o.bi = inst_i[20:16];
        dec_o.flags[FLAG_WRITES_LR] = inst_i[0];
        dec_o.flags[FLAG_UNCOND]    = bo[4] & bo[2];
        valid_o  = (kind != BR_NONE);

        case (kind)
            BR_BC: begin
                dec_o.opcode = OPC_BC;
                offset = ADDR_W'($signed({inst_i[15:2], 2'b00}));
                dec_o.flags[FLAG_READS_CTR]  = ~bo[2];
                dec_o.flags[FLAG_WRITES_CTR] = ~bo[2];
            end
            BR_B: begin
                dec_o.opcode = OPC_B;
                offset = ADDR_W'($signed({inst_i[25:2], 2'b00}));
                dec_o.flags[FLAG_UNCOND] = 1'b1;
            end
            BR_BCLR: begin
                dec_o.opcode = OPC_BCLR;
                dec_o.flags[FLAG_READS_CTR]  = ~bo[2];
                dec_o.flags[FLAG_WRITES_CTR] = ~bo[2];
                dec_o.flags[FLAG_READS_LR]   = 1'b1;
            end
            BR_BCCTR: begin
                dec_o.opcode = OPC_BCCTR;
                dec_o.flags[FLAG_READS_CTR] = 1'b1;
            end
            default: begin
                dec_o.opcode = '0;
            end
        endcase

        // Register-indirect branches carry no computed target.
        if (kind == BR_BC || kind == BR_B) begin
            target_o = inst_i[1] ? offset : addr_i + offset;
            if (!is64_i) begin
                target_o = target_o & LOW32_MASK;
            end
        end
    end

endmodule

// File: rtl/branch_decode_unit.sv
// Multi-lane branch decoder feeding an in-order output queue; invalid lanes
// are dropped and counted.
module branch_decode_unit
    import branch_decode_pkg::*;
#(
    parameter int LANES                   = 2,
    parameter int FIFO_DEPTH              = 8,
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16
) (
    input  logic                                 clock_i,
    input  logic                                 reset_ni,
    input  logic                                 flush_i,
    input  logic [LANES-1:0]                     in_valid_i,
    output logic                                 in_ready_o,
    input  logic [32*LANES-1:0]                  in_inst_i,
    input  logic [addressWidth*LANES-1:0]        in_addr_i,
    input  logic [instructionCounterWidth*LANES-1:0] in_majId_i,
    input  logic [PidSize*LANES-1:0]             in_pid_i,
    input  logic [TidSize*LANES-1:0]             in_tid_i,
    input  logic [LANES-1:0]                     in_is64_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [11:0]                          out_opcode_o,
    output logic [addressWidth-1:0]              out_target_o,
    output logic [4:0]                           out_bo_o,
    output logic [4:0]                           out_bi_o,
    output logic [4:0]                           out_flags_o,
    output logic [addressWidth-1:0]              out_addr_o,
    output logic [instructionCounterWidth-1:0]   out_majId_o,
    output logic [PidSize-1:0]                   out_pid_o,
    output logic [TidSize-1:0]                   out_tid_o,
    output logic                                 out_is64_o,
    output logic [2:0]                           out_funit_o,
    output logic [7:0]                           invalid_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        queue_entry_t                       dec;
        logic [addressWidth-1:0]            target;
        logic [addressWidth-1:0]            addr;
        logic [instructionCounterWidth-1:0] majid;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic                               is64;
    } slot_t;

    slot_t        slot_q [FIFO_DEPTH];
    slot_t        slot_d [FIFO_DEPTH];
    ptr_t         rd_ptr_q, rd_ptr_d;
    ptr_t         wr_ptr_q, wr_ptr_d;
    cnt_t         count_q, count_d;
    logic [7:0]   inv_cnt_q, inv_cnt_d;

    logic [LANES-1:0]        lane_ok;
    queue_entry_t            lane_dec    [LANES];
    logic [addressWidth-1:0] lane_target [LANES];
    slot_t                   lane_slot   [LANES];

    logic accept;
    logic pop;
    cnt_t free;
    cnt_t push_cnt;
    ptr_t widx;
    logic [2:0] inv_lanes;
    logic [8:0] inv_sum;
    slot_t head;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        branch_lane_decode #(.ADDR_W(addressWidth)) u_dec (
            .inst_i   (in_inst_i[32*l +: 32]),
            .addr_i   (in_addr_i[addressWidth*l +: addressWidth]),
            .is64_i   (in_is64_i[l]),
            .valid_o  (lane_ok[l]),
            .dec_o    (lane_dec[l]),
            .target_o (lane_target[l])
        );

        assign lane_slot[l] = '{
            dec:    lane_dec[l],
            target: lane_target[l],
            addr:   in_addr_i[addressWidth*l +: addressWidth],
            majid:  in_majId_i[instructionCounterWidth*l +: instructionCounterWidth],
            pid:    in_pid_i[PidSize*l +: PidSize],
            tid:    in_tid_i[TidSize*l +: TidSize],
            is64:   in_is64_i[l]
        };
    end

    // Readiness ignores a same-cycle pop so it never depends on out_ready_i.
    assign free        = cnt_t'(FIFO_DEPTH) - count_q;
    assign in_ready_o  = reset_ni && (free >= cnt_t'(LANES)) && !flush_i;
    assign out_valid_o = (count_q != '0);
    assign accept      = in_ready_o && (|in_valid_i);
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        slot_d    = slot_q;
        push_cnt  = '0;
        inv_lanes = '0;
        widx      = '0;
        for (int l = 0; l < LANES; l++) begin
            if (accept && in_valid_i[l]) begin
                if (lane_ok[l]) begin
                    widx         = wr_ptr_q + ptr_t'(push_cnt);
                    slot_d[widx] = lane_slot[l];
                    push_cnt     = push_cnt + cnt_t'(1);
                end else begin
                    inv_lanes = inv_lanes + 3'd1;
                end
            end
        end

        inv_sum   = {1'b0, inv_cnt_q} + 9'(inv_lanes);
        inv_cnt_d = inv_sum[8] ? 8'hFF : inv_sum[7:0];

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_t'(pop);
            wr_ptr_d = wr_ptr_q + ptr_t'(push_cnt);
            count_d  = count_q + push_cnt - cnt_t'(pop);
        end
    end

    // NOTE: the storage array is reset because out_* read it directly and
    // must show zero after reset; every other flop here is reset as well.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot_q    <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            inv_cnt_q <= '0;
        end else begin
            slot_q    <= slot_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    assign head            = slot_q[rd_ptr_q];
    assign out_opcode_o    = head.dec.opcode;
    assign out_bo_o        = head.dec.bo;
    assign out_bi_o        = head.dec.bi;
    assign out_flags_o     = head.dec.flags;
    assign out_target_o    = head.target;
    assign out_addr_o      = head.addr;
    assign out_majId_o     = head.majid;
    assign out_pid_o       = head.pid;
    assign out_tid_o       = head.tid;
    assign out_is64_o      = head.is64;
    assign out_funit_o     = BRANCH_UNIT_ID;
    assign invalid_count_o = inv_cnt_q;

endmodule

// File: tb/tb_branch_decode_unit.sv
// Randomized self-checking bench for branch_decode_unit against a queue-based
// reference model that decodes from big-endian instruction fields.
module tb_branch_decode_unit;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 64;
    localparam int IW    = 64;
    localparam int PW    = 20;
    localparam int TW    = 16;

    logic              clock_i = 1'b0;
    logic              reset_ni;
    logic              flush_i;
    logic [LANES-1:0]  in_valid_i;
    logic              in_ready_o;
    logic [32*LANES-1:0] in_inst_i;
    logic [AW*LANES-1:0] in_addr_i;
    logic [IW*LANES-1:0] in_majId_i;
    logic [PW*LANES-1:0] in_pid_i;
    logic [TW*LANES-1:0] in_tid_i;
    logic [LANES-1:0]  in_is64_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [11:0]       out_opcode_o;
    logic [AW-1:0]     out_target_o;
    logic [4:0]        out_bo_o, out_bi_o, out_flags_o;
    logic [AW-1:0]     out_addr_o;
    logic [IW-1:0]     out_majId_o;
    logic [PW-1:0]     out_pid_o;
    logic [TW-1:0]     out_tid_o;
    logic              out_is64_o;
    logic [2:0]        out_funit_o;
    logic [7:0]        invalid_count_o;

    branch_decode_unit #(
        .LANES(LANES), .FIFO_DEPTH(DEPTH), .addressWidth(AW),
        .instructionCounterWidth(IW), .PidSize(PW), .TidSize(TW)
    ) dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_inst_i(in_inst_i),
        .in_addr_i(in_addr_i), .in_majId_i(in_majId_i), .in_pid_i(in_pid_i),
        .in_tid_i(in_tid_i), .in_is64_i(in_is64_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_opcode_o(out_opcode_o), .out_target_o(out_target_o),
        .out_bo_o(out_bo_o), .out_bi_o(out_bi_o), .out_flags_o(out_flags_o),
        .out_addr_o(out_addr_o), .out_majId_o(out_majId_o), .out_pid_o(out_pid_o),
        .out_tid_o(out_tid_o), .out_is64_o(out_is64_o), .out_funit_o(out_funit_o),
        .invalid_count_o(invalid_count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [11:0] opcode;
        logic [63:0] target;
        logic [4:0]  bo, bi, flags;
        logic [63:0] addr, majid;
        logic [19:0] pid;
        logic [15:0] tid;
        logic        is64;
    } exp_t;

    exp_t model[$];
    int   inv_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field extraction using big-endian bit numbering [a:b] of a 32-bit word.
    function automatic int unsigned fld(input int unsigned w, input int a, input int b);
        return (w >> (31 - b)) & ((32'd1 << (b - a + 1)) - 1);
    endfunction

    function automatic longint sext(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic void ref_decode(input logic [31:0] inst, input logic [63:0] addr,
                                       input logic is64, output bit ok, output exp_t e);
        int unsigned w, prim, xo;
        bit bo0, bo2, aa, lk;
        longint off;
        w    = inst;
        prim = fld(w, 0, 5);
        xo   = fld(w, 21, 30);
        bo0  = fld(w, 6, 6) != 0;
        bo2  = fld(w, 8, 8) != 0;
        aa   = fld(w, 30, 30) != 0;
        lk   = fld(w, 31, 31) != 0;
        e = '{default: '0};
        e.bo   = 5'(fld(w, 6, 10));
        e.bi   = 5'(fld(w, 11, 15));
        e.addr = addr;
        e.is64 = is64;
        ok = 1'b1;
        off = 0;
        if (prim == 16) begin
            e.opcode = 12'd25;
            off = sext(longint'(fld(w, 16, 29)) * 4, 16);
            e.flags = {!bo2, !bo2, 1'b0, lk, bo0 && bo2};
        end else if (prim == 18) begin
            e.opcode = 12'd26;
            off = sext(longint'(fld(w, 6, 29)) * 4, 26);
            e.flags = {1'b0, 1'b0, 1'b0, lk, 1'b1};
        end else if (prim == 19 && xo == 16) begin
            e.opcode = 12'd27;
            e.flags = {!bo2, !bo2, 1'b1, lk, bo0 && bo2};
        end else if (prim == 19 && xo == 528) begin
            e.opcode = 12'd28;
            e.flags = {1'b1, 1'b0, 1'b0, lk, bo0 && bo2};
        end else begin
            ok = 1'b0;
        end
        if (prim == 16 || prim == 18) begin
            e.target = aa ? 64'(off) : addr + 64'(off);
            if (!is64) e.target = e.target & 64'hFFFF_FFFF;
        end
    endfunction

    function automatic logic [31:0] rand_branch();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:26] = 6'd16;
            1: r[31:26] = 6'd18;
            2: begin r[31:26] = 6'd19; r[10:1] = 10'd16;  end
            default: begin r[31:26] = 6'd19; r[10:1] = 10'd528; end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        if ($urandom_range(0, 2) != 0) return rand_branch();
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r[31:26] = 6'd19;
        return r;
    endfunction

    task automatic set_lane(input int l, input logic [31:0] inst, input logic [63:0] addr,
                            input logic is64);
        in_valid_i[l]          = 1'b1;
        in_inst_i[l*32 +: 32]  = inst;
        in_addr_i[l*AW +: AW]  = addr;
        in_majId_i[l*IW +: IW] = {$urandom, $urandom};
        in_pid_i[l*PW +: PW]   = PW'($urandom);
        in_tid_i[l*TW +: TW]   = TW'($urandom);
        in_is64_i[l]           = is64;
    endtask

    task automatic clear_lanes();
        in_valid_i = '0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid_o, model.size() > 0);
        check("invalid_count", invalid_count_o, inv_cnt);
        check("funit", out_funit_o, 3'd6);
        if (model.size() > 0) begin
            check("opcode", out_opcode_o, model[0].opcode);
            check("target", out_target_o, model[0].target);
            check("bo_bi_flags", {out_bo_o, out_bi_o, out_flags_o},
                  {model[0].bo, model[0].bi, model[0].flags});
            check("addr", out_addr_o, model[0].addr);
            check("majid", out_majId_o, model[0].majid);
            check("pid_tid_is64", {out_pid_o, out_tid_o, out_is64_o},
                  {model[0].pid, model[0].tid, model[0].is64});
        end
    endtask

    // One clock: check readiness, advance, update the model, check outputs.
    task automatic tick();
        bit   exp_ready, ok;
        exp_t e;
        #1;
        exp_ready = (DEPTH - model.size() >= LANES) && !flush_i;
        check("in_ready", in_ready_o, exp_ready);
        @(posedge clock_i);
        if (flush_i) begin
            model.delete();
        end else begin
            if (model.size() > 0 && out_ready_i) void'(model.pop_front());
            if (exp_ready && |in_valid_i) begin
                for (int l = 0; l < LANES; l++) begin
                    if (in_valid_i[l]) begin
                        ref_decode(in_inst_i[l*32 +: 32], in_addr_i[l*AW +: AW], in_is64_i[l], ok, e);
                        if (ok) begin
                            e.majid = in_majId_i[l*IW +: IW];
                            e.pid   = in_pid_i[l*PW +: PW];
                            e.tid   = in_tid_i[l*TW +: TW];
                            model.push_back(e);
                        end else if (inv_cnt < 255) begin
                            inv_cnt++;
                        end
                    end
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic push_five();
        out_ready_i = 1'b0;
        set_lane(0, rand_branch(), {$urandom, $urandom}, 1'b1);
        set_lane(1, rand_branch(), {$urandom, $urandom}, 1'b1);
        tick();
        set_lane(0, rand_branch(), {$urandom, $urandom}, 1'b0);
        set_lane(1, rand_branch(), {$urandom, $urandom}, 1'b1);
        tick();
        set_lane(0, rand_branch(), {$urandom, $urandom}, 1'b1);
        set_lane(1, 32'h7C00_0000, 64'h0, 1'b1);
        tick();
        clear_lanes();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ni    = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = '0;
        in_inst_i   = '0;
        in_addr_i   = '0;
        in_majId_i  = '0;
        in_pid_i    = '0;
        in_tid_i    = '0;
        in_is64_i   = '0;

        #12;
        check("reset_in_ready", in_ready_o, 1'b0);
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_invalid_count", invalid_count_o, 8'd0);
        check("reset_opcode", out_opcode_o, 12'd0);
        check("reset_target", out_target_o, 64'd0);
        reset_ni = 1'b1;
        @(posedge clock_i);
        #1;

        // bc with negative displacement
        set_lane(0, 32'h4280_FFFC, 64'h1000, 1'b1);
        tick();
        check("bc_opcode", out_opcode_o, 12'd25);
        check("bc_target", out_target_o, 64'hFFC);
        check("bc_bo", out_bo_o, 5'd20);
        check("bc_flags", out_flags_o, 5'b00001);
        clear_lanes();
        out_ready_i = 1'b1;
        tick();

        // b with link plus bclr, popped in lane order
        out_ready_i = 1'b0;
        set_lane(0, 32'h4800_0011, 64'h2000, 1'b1);
        set_lane(1, 32'h4E80_0020, 64'h2004, 1'b1);
        tick();
        check("b_opcode", out_opcode_o, 12'd26);
        check("b_target", out_target_o, 64'h2010);
        check("b_flags", out_flags_o, 5'b00011);
        clear_lanes();
        out_ready_i = 1'b1;
        tick();
        check("bclr_opcode", out_opcode_o, 12'd27);
        check("bclr_flags", out_flags_o, 5'b00101);
        tick();
        check("drained", out_valid_o, 1'b0);

        // invalid lane dropped, bcctr kept
        out_ready_i = 1'b0;
        set_lane(0, 32'h7C00_0000, 64'h3000, 1'b1);
        set_lane(1, 32'h4E80_0420, 64'h3004, 1'b1);
        tick();
        check("bcctr_opcode", out_opcode_o, 12'd28);
        check("bcctr_flags", out_flags_o, 5'b10001);
        check("invalid_once", invalid_count_o, 8'd1);
        clear_lanes();
        out_ready_i = 1'b1;
        tick();

        // 32-bit wrap of a relative target
        set_lane(0, 32'h4800_0008, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        tick();
        check("wrap_target", out_target_o, 64'h4);
        clear_lanes();
        tick();

        // fill with consumer stalled, then drain
        out_ready_i = 1'b0;
        for (int b = 0; b < DEPTH / LANES; b++) begin
            set_lane(0, rand_branch(), {$urandom, $urandom}, 1'($urandom));
            set_lane(1, rand_branch(), {$urandom, $urandom}, 1'($urandom));
            tick();
        end
        check("full_not_ready", in_ready_o, 1'b0);
        set_lane(0, rand_branch(), {$urandom, $urandom}, 1'b1);
        tick();
        clear_lanes();
        out_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        check("drain_empty", out_valid_o, 1'b0);

        // flush with five entries queued; offered bundle must be discarded
        push_five();
        flush_i = 1'b1;
        set_lane(0, rand_branch(), {$urandom, $urandom}, 1'b1);
        tick();
        check("flush_empty", out_valid_o, 1'b0);
        flush_i = 1'b0;
        clear_lanes();
        #1;
        check("ready_after_flush", in_ready_o, 1'b1);
        tick();

        // asynchronous reset with five entries queued
        push_five();
        reset_ni = 1'b0;
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b0);
        check("rst_invalid_count", invalid_count_o, 8'd0);
        model.delete();
        inv_cnt = 0;
        @(posedge clock_i);
        #1;
        reset_ni = 1'b1;
        #1;
        check("ready_after_reset", in_ready_o, 1'b1);
        @(posedge clock_i);
        #1;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            flush_i     = ($urandom_range(0, 49) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            clear_lanes();
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 2) != 0) begin
                    logic [63:0] a;
                    a = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) a[31:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    set_lane(l, rand_inst(), a, 1'($urandom));
                end
            end
            tick();
        end

        flush_i = 1'b0;
        clear_lanes();
        out_ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
